// File: rtl/register_file32.sv
// register_file32: 32-entry register file with one synchronous write port
// (one-hot select from decoder5_32), two combinational read ports, and a
// sticky flag for writes attempted with a malformed select vector.
module register_file32 #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [31:0]      wsel,
   input  logic [WIDTH-1:0] wdata,
   input  logic [4:0]       ra,
   input  logic [4:0]       rb,
   output logic [WIDTH-1:0] qa,
   output logic [WIDTH-1:0] qb,
   output logic             err
);

   localparam int unsigned NREG = 32;
   localparam int unsigned AW   = 5;

   logic [WIDTH-1:0] regs [NREG];
   logic             wsel_onehot;
   logic             wr_ok;
   logic             wr_bad;

   // Classify the select vector: exactly one bit set is the only legal write.
   always_comb begin
      wsel_onehot = 1'b0;
      if (wsel != 32'd0) begin
         wsel_onehot = ((wsel & (wsel - 32'd1)) == 32'd0);
      end
      wr_ok  = we & wsel_onehot;
      wr_bad = we & ~wsel_onehot;
   end

   // Register storage; reset wins over any write on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NREG; k++) begin
            regs[k] <= '0;
         end
      end else if (wr_ok) begin
         for (int k = 0; k < NREG; k++) begin
            if (wsel[k] && !(k == 0 && ZERO_REG != 0)) begin
               regs[k] <= wdata;
            end
         end
      end
   end

   // Sticky select-error flag: only a reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (wr_bad) begin
         err <= 1'b1;
      end
   end

   // Combinational read ports; address 0 is hardwired to zero when enabled.
   always_comb begin
      qa = regs[ra];
      qb = regs[rb];
      if (ZERO_REG != 0 && ra == AW'(0)) begin
         qa = '0;
      end
      if (ZERO_REG != 0 && rb == AW'(0)) begin
         qb = '0;
      end
   end

endmodule

// File: tb/tb_register_file32.sv
// tb_register_file32: directed vector table plus hand-written sequences for
// register_file32, run on a ZERO_REG=1 and a ZERO_REG=0 instance in parallel.
module tb_register_file32;

   logic        clk;
   logic        rst;
   logic        we;
   logic [31:0] wsel;
   logic [31:0] wdata;
   logic [4:0]  ra;
   logic [4:0]  rb;
   logic [31:0] qa_z, qb_z, qa_n, qb_n;
   logic        err_z, err_n;

   int n_chk;
   int n_fail;

   register_file32 #(.WIDTH(32), .ZERO_REG(1)) u_z (
      .clk(clk), .rst(rst), .we(we), .wsel(wsel), .wdata(wdata),
      .ra(ra), .rb(rb), .qa(qa_z), .qb(qb_z), .err(err_z)
   );

   register_file32 #(.WIDTH(32), .ZERO_REG(0)) u_n (
      .clk(clk), .rst(rst), .we(we), .wsel(wsel), .wdata(wdata),
      .ra(ra), .rb(rb), .qa(qa_n), .qb(qb_n), .err(err_n)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we;
      logic [31:0] wsel;
      logic [31:0] wdata;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] qa;     // ZERO_REG=1 instance
      logic [31:0] qb;
      logic [31:0] qa_n;   // ZERO_REG=0 instance
      logic [31:0] qb_n;
      logic        err;    // same for both instances
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic r, input logic w, input logic [31:0] s,
                               input logic [31:0] d, input logic [4:0] a, input logic [4:0] b,
                               input logic [31:0] ea, input logic [31:0] eb,
                               input logic [31:0] ean, input logic [31:0] ebn, input logic ee);
      vec_t v;
      v.rst = r; v.we = w; v.wsel = s; v.wdata = d; v.ra = a; v.rb = b;
      v.qa = ea; v.qb = eb; v.qa_n = ean; v.qb_n = ebn; v.err = ee;
      return v;
   endfunction

   // Behavioural stand-in for the upstream decoder5_32.
   function automatic logic [31:0] dec5_32(input logic [4:0] a, input logic en);
      return en ? (32'd1 << a) : 32'd0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; we = 1'b0; wsel = 32'd0; wdata = 32'd0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b1; we = 1'b0; wsel = 32'd0; wdata = 32'd0; ra = 5'd0; rb = 5'd0;

      //           rst we  wsel          wdata         ra  rb  qa(z)         qb(z)         qa(n)         qb(n)         err
      vecs[0]  = mk(1, 0, 32'h0000_0000, 32'h0,        0, 31, 32'h0,        32'h0,        32'h0,        32'h0,        0);
      vecs[1]  = mk(0, 1, 32'h0000_0020, 32'hDEADBEEF, 5,  0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        0);
      vecs[2]  = mk(0, 1, 32'h8000_0000, 32'h12345678, 5, 31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 0);
      vecs[3]  = mk(0, 1, 32'h0000_0001, 32'hFFFFFFFF, 0,  5, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFF, 32'hDEADBEEF, 0);
      vecs[4]  = mk(0, 1, 32'h0000_0030, 32'hAAAAAAAA, 4,  5, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1);
      vecs[5]  = mk(0, 1, 32'h0000_0010, 32'h44,       4,  5, 32'h44,       32'hDEADBEEF, 32'h44,       32'hDEADBEEF, 1);
      vecs[6]  = mk(0, 0, 32'h0000_0000, 32'h0,        4, 31, 32'h44,       32'h12345678, 32'h44,       32'h12345678, 1);
      vecs[7]  = mk(1, 0, 32'h0000_0000, 32'h0,        4, 31, 32'h0,        32'h0,        32'h0,        32'h0,        0);
      vecs[8]  = mk(0, 0, 32'h0000_0003, 32'h77,       0,  1, 32'h0,        32'h0,        32'h0,        32'h0,        0);
      vecs[9]  = mk(0, 1, 32'h0000_0000, 32'h11,       0,  1, 32'h0,        32'h0,        32'h0,        32'h0,        1);
      vecs[10] = mk(1, 0, 32'h0000_0000, 32'h0,        0,  1, 32'h0,        32'h0,        32'h0,        32'h0,        0);
      vecs[11] = mk(0, 1, 32'h0000_0080, 32'h55,       7,  0, 32'h55,       32'h0,        32'h55,       32'h0,        0);
      vecs[12] = mk(1, 1, 32'h0000_0080, 32'h99,       7,  7, 32'h0,        32'h0,        32'h0,        32'h0,        0);
      vecs[13] = mk(0, 1, 32'hFFFF_FFFF, 32'h1,        7,  0, 32'h0,        32'h0,        32'h0,        32'h0,        1);
      vecs[14] = mk(0, 1, 32'h0001_0000, 32'hCAFE,    16,  7, 32'hCAFE,     32'h0,        32'hCAFE,     32'h0,        1);

      // Table: apply each record for one edge, compare after the edge.
      for (int i = 0; i < NVEC; i++) begin
         rst = vecs[i].rst; we = vecs[i].we; wsel = vecs[i].wsel;
         wdata = vecs[i].wdata; ra = vecs[i].ra; rb = vecs[i].rb;
         tick();
         chk($sformatf("vec%0d qa_z", i), qa_z, vecs[i].qa);
         chk($sformatf("vec%0d qb_z", i), qb_z, vecs[i].qb);
         chk($sformatf("vec%0d qa_n", i), qa_n, vecs[i].qa_n);
         chk($sformatf("vec%0d qb_n", i), qb_n, vecs[i].qb_n);
         chk($sformatf("vec%0d err_z", i), 32'(err_z), 32'(vecs[i].err));
         chk($sformatf("vec%0d err_n", i), 32'(err_n), 32'(vecs[i].err));
      end

      // Reset sweep: every address reads zero after reset.
      do_reset();
      for (int i = 0; i < 32; i++) begin
         ra = 5'(i); rb = 5'(31 - i);
         #1;
         chk($sformatf("rst_sweep qa_z[%0d]", i), qa_z, 32'h0);
         chk($sformatf("rst_sweep qb_n[%0d]", 31 - i), qb_n, 32'h0);
      end
      chk("rst_sweep err_z", 32'(err_z), 32'h0);

      // Write latency: old value before the edge, new value after; reads are zero-latency.
      we = 1'b1; wsel = 32'h0000_0020; wdata = 32'hDEADBEEF; ra = 5'd5; rb = 5'd5;
      #1;
      chk("pre_edge qa_z", qa_z, 32'h0);
      tick();
      we = 1'b0; wsel = 32'd0;
      chk("post_edge qa_z", qa_z, 32'hDEADBEEF);
      chk("same_reg qb_z", qb_z, 32'hDEADBEEF);
      ra = 5'd6;
      #1;
      chk("comb_read qa_z", qa_z, 32'h0);

      // Back-to-back writes on consecutive edges, including a rewrite of the same register.
      we = 1'b1; wsel = 32'h2; wdata = 32'h1111;
      tick();
      wsel = 32'h4; wdata = 32'h2222;
      tick();
      wsel = 32'h4; wdata = 32'h3333;
      tick();
      we = 1'b0; wsel = 32'd0; ra = 5'd1; rb = 5'd2;
      #1;
      chk("b2b r1", qa_z, 32'h1111);
      chk("b2b r2", qb_z, 32'h3333);
      chk("b2b err", 32'(err_z), 32'h0);

      // Full sweep through the decoder model.
      do_reset();
      for (int i = 0; i < 32; i++) begin
         we = 1'b1; wsel = dec5_32(5'(i), we); wdata = 32'(i) * 32'h01010101;
         tick();
      end
      we = 1'b0; wsel = dec5_32(5'd0, we);
      for (int i = 0; i < 32; i++) begin
         ra = 5'(i); rb = 5'(31 - i);
         #1;
         chk($sformatf("sweep qa_z[%0d]", i), qa_z, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
         chk($sformatf("sweep qa_n[%0d]", i), qa_n, 32'(i) * 32'h01010101);
         chk($sformatf("sweep qb_n[%0d]", 31 - i), qb_n, 32'(31 - i) * 32'h01010101);
      end
      chk("sweep err_z", 32'(err_z), 32'h0);
      chk("sweep err_n", 32'(err_n), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
